// File: rtl/prince_cms_pkg.sv
// Shared constants and helpers for the masked PRINCE S-box: lookup tables,
// ANF extraction, share-tuple indexing and the fresh-randomness width.
package prince_cms_pkg;

    // Nibble for index x sits at bits [4x+3:4x].
    localparam logic [63:0] SBOX_FWD = 64'h4D5E_0876_19CA_23FB;
    localparam logic [63:0] SBOX_INV = 64'h1CE5_046A_98DF_237B;

    function automatic int rnd_width(input int shares);
        return 4 * (shares ** 3 - shares);
    endfunction

    // Bit 16*b+m is set when monomial m (product of the x bits set in m)
    // appears in the ANF of output bit b; in-place Moebius transform.
    function automatic logic [63:0] anf_masks(input logic [63:0] tbl);
        logic [15:0] f;
        logic [63:0] res;
        res = '0;
        for (int b = 0; b < 4; b++) begin
            for (int x = 0; x < 16; x++) f[x] = tbl[4 * x + b];
            for (int i = 0; i < 4; i++)
                for (int x = 0; x < 16; x++)
                    if (((x >> i) & 1) == 1) f[x] = f[x] ^ f[x ^ (1 << i)];
            res[16 * b +: 16] = f;
        end
        return res;
    endfunction

    function automatic int tuple_idx(input int i, input int j, input int k, input int shares);
        return (i * shares + j) * shares + k;
    endfunction

    // Position of (s,j,k) among the non-diagonal members of group s.
    function automatic int grp_member(input int s, input int j, input int k, input int shares);
        int n;
        n = j * shares + k;
        return (n > s * shares + s) ? n - 1 : n;
    endfunction

endpackage

// File: rtl/prince_cms_partial.sv
// One CMS partial nibble for share tuple (I,J,K); reads only shares I, J, K.
// With PRINCE_SBOX_INV_EN defined, input inv selects the inverse S-box.
module prince_cms_partial
    import prince_cms_pkg::*;
#(
    parameter int I = 0,
    parameter int J = 0,
    parameter int K = 0
) (
    input  logic [3:0] si,
    input  logic [3:0] sj,
    input  logic [3:0] sk,
`ifdef PRINCE_SBOX_INV_EN
    input  logic       inv,
`endif
    output logic [3:0] p
);

    localparam logic [63:0] ANF_FWD = anf_masks(SBOX_FWD);

    logic [63:0] anf;
`ifdef PRINCE_SBOX_INV_EN
    localparam logic [63:0] ANF_INV = anf_masks(SBOX_INV);
    assign anf = inv ? ANF_INV : ANF_FWD;
`else
    assign anf = ANF_FWD;
`endif

    // Monomial term owned by this tuple: cubic terms by (i,j,k), quadratic
    // by (i,j,j), linear by (i,i,i), the constant by (0,0,0).
    function automatic logic mono_term(input logic [3:0] m, input logic [3:0] a,
                                       input logic [3:0] b, input logic [3:0] c);
        logic [1:0] v [3];
        int d;
        logic t;
        v = '{2'd0, 2'd0, 2'd0};
        d = 0;
        for (int n = 0; n < 4; n++) begin
            if (m[n]) begin
                if (d < 3) v[d] = 2'(n);
                d++;
            end
        end
        case (d)
            0:       t = (I == 0) && (J == 0) && (K == 0);
            1:       t = ((I == J) && (J == K)) ? a[v[0]] : 1'b0;
            2:       t = (J == K) ? (a[v[0]] & b[v[1]]) : 1'b0;
            3:       t = a[v[0]] & b[v[1]] & c[v[2]];
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    always_comb begin
        p = '0;
        for (int b = 0; b < 4; b++)
            for (int m = 0; m < 16; m++)
                if (anf[16 * b + m]) p[b] = p[b] ^ mono_term(4'(m), si, sj, sk);
    end

endmodule

// File: rtl/prince_sbox_cms_pipe.sv
// Two-stage CMS-masked PRINCE S-box: refreshed partials, then compression.
// Define PRINCE_SBOX_INV_EN to add the inv port and the inverse S-box mode.
module prince_sbox_cms_pipe
    import prince_cms_pkg::*;
#(
    parameter int SHARES = 2,
    localparam int RND_W = rnd_width(SHARES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [4*SHARES-1:0]   in_shares,
    input  logic [RND_W-1:0]      rnd,
`ifdef PRINCE_SBOX_INV_EN
    input  logic                  inv,
`endif
    output logic                  out_valid,
    output logic [4*SHARES-1:0]   out_shares
);

    localparam int NT = SHARES ** 3;
    localparam int NG = SHARES * SHARES;
    localparam int G  = NG - 1;

    logic [3:0]          p_comb [NT];
    logic [3:0]          p_q    [NT];
    logic [1:0]          vld;
    logic [4*SHARES-1:0] out_next;

    for (genvar i = 0; i < SHARES; i++) begin : g_i
        for (genvar j = 0; j < SHARES; j++) begin : g_j
            for (genvar k = 0; k < SHARES; k++) begin : g_k
                localparam int T = tuple_idx(i, j, k, SHARES);
                logic [3:0] raw;

                prince_cms_partial #(.I(i), .J(j), .K(k)) u_part (
                    .si  (in_shares[4*i +: 4]),
                    .sj  (in_shares[4*j +: 4]),
                    .sk  (in_shares[4*k +: 4]),
`ifdef PRINCE_SBOX_INV_EN
                    .inv (inv),
`endif
                    .p   (raw)
                );

                // Ring refresh cancels across each group, so compression is unbiased.
                if ((i == j) && (j == k)) begin : g_diag
                    assign p_comb[T] = raw;
                end else begin : g_ref
                    localparam int N  = grp_member(i, j, k, SHARES);
                    localparam int N1 = (N + 1) % G;
                    assign p_comb[T] = raw ^ rnd[4*(i*G + N) +: 4] ^ rnd[4*(i*G + N1) +: 4];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
            for (int t = 0; t < NT; t++) p_q[t] <= '0;
        end else begin
            vld <= {vld[0], in_valid};
            if (in_valid)
                for (int t = 0; t < NT; t++) p_q[t] <= p_comb[t];
        end
    end

    always_comb begin
        out_next = '0;
        for (int s = 0; s < SHARES; s++)
            for (int m = 0; m < NG; m++)
                out_next[4*s +: 4] = out_next[4*s +: 4] ^ p_q[s*NG + m];
    end

    always_ff @(posedge clk) begin
        if (rst)
            out_shares <= '0;
        else if (vld[0])
            out_shares <= out_next;
    end

    assign out_valid = vld[1];

endmodule
